// File: rtl/inst_mem_pkg.sv
// Shared defaults, response type and address-check helper for the
// pipelined instruction memory.
package inst_mem_pkg;

  localparam int          DEF_DATA_W    = 32;
  localparam int          DEF_ADDR_W    = 64;
  localparam int          DEF_DEPTH     = 128;
  localparam logic [63:0] DEF_BASE_ADDR = 64'h0;

  // Response entry as held in the response buffer (default word width).
  typedef struct packed {
    logic                  err;
    logic [DEF_DATA_W-1:0] rdata;
  } resp_t;

  // Result of decoding a byte address against the memory window.
  typedef struct packed {
    logic [63:0] idx;
    logic        misaligned;
    logic        oor;
  } addr_chk_t;

  // Word index plus misaligned / out-of-range flags for a byte address.
  // Addresses are zero-extended to 64 bits by the caller.
  function automatic addr_chk_t check_addr(
    input logic [63:0] addr,
    input logic [63:0] base,
    input int unsigned off_bits,
    input logic [63:0] depth
  );
    addr_chk_t   c;
    logic [63:0] off_mask;
    off_mask     = (64'd1 << off_bits) - 64'd1;
    c.idx        = (addr - base) >> off_bits;
    c.misaligned = (addr & off_mask) != 64'd0;
    c.oor        = (addr < base) || (c.idx >= depth);
    return c;
  endfunction

endpackage

// File: rtl/inst_resp_fifo.sv
// Two-entry synchronous FIFO holding fetch responses. Occupancy is
// registered so full/empty never depend combinationally on push/pop.
module inst_resp_fifo #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  logic [W-1:0] slot [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop  && (count != 2'd0);

  // Pointer and occupancy control; flush empties the buffer outright.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Entry storage; contents only matter while counted as occupied.
  always_ff @(posedge clk) begin
    if (do_push && !flush) slot[wr_ptr] <= din;
  end

  assign dout  = slot[rd_ptr];
  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);

endmodule

// File: rtl/inst_sram_pipe.sv
// Instruction memory with valid/ready fetch handshake, synchronous read
// into a 2-entry response buffer, byte-strobed loader port and flush.
module inst_sram_pipe
  import inst_mem_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DEPTH     = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  input  logic                flush,
  input  logic [DATA_W/8-1:0] wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data
);

  localparam int          BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int          IDX_W = $clog2(DEPTH);

  // Response entry sized to this instance's word width.
  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] rdata;
  } resp_p_t;

  logic [DATA_W-1:0] mem [DEPTH];

  addr_chk_t         rd_chk_p0;
  addr_chk_t         wr_chk_p0;
  logic [IDX_W-1:0]  rd_idx_p0;
  logic [IDX_W-1:0]  wr_idx_p0;
  logic              rd_bad_p0;
  logic              wr_ok_p0;
  logic [DATA_W-1:0] rd_word_p0;
  logic              push_p0;
  resp_p_t           push_data_p0;
  resp_p_t           head_p1;
  logic              empty_p1;
  logic              full_p1;
  logic              pop_p1;
  logic              unused_idx_hi;

  // ---- stage p0: address decode, memory access, response capture ----
  assign rd_chk_p0 = check_addr(64'(req_addr), 64'(BASE_ADDR), OFF_W, 64'(DEPTH));
  assign wr_chk_p0 = check_addr(64'(wr_addr),  64'(BASE_ADDR), OFF_W, 64'(DEPTH));

  assign rd_idx_p0 = rd_chk_p0.idx[IDX_W-1:0];
  assign wr_idx_p0 = wr_chk_p0.idx[IDX_W-1:0];
  assign rd_bad_p0 = rd_chk_p0.misaligned || rd_chk_p0.oor;
  assign wr_ok_p0  = !wr_chk_p0.misaligned && !wr_chk_p0.oor;

  // Upper index bits only feed the range check inside the helper.
  assign unused_idx_hi = ^{rd_chk_p0.idx[63:IDX_W], wr_chk_p0.idx[63:IDX_W]};

  // Byte-strobed loader writes; rejected addresses are dropped.
  always_ff @(posedge clk) begin
    if (wr_ok_p0) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_en[b]) mem[wr_idx_p0][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Write-first read: a same-index write overlays its strobed bytes.
  always_comb begin
    rd_word_p0 = mem[rd_idx_p0];
    if (wr_ok_p0 && (wr_idx_p0 == rd_idx_p0)) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_en[b]) rd_word_p0[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  // Ready depends only on registered occupancy and flush, never on resp_ready.
  assign req_ready = !full_p1 && !flush;
  assign push_p0   = req_valid && req_ready;

  assign push_data_p0.err   = rd_bad_p0;
  assign push_data_p0.rdata = rd_bad_p0 ? '0 : rd_word_p0;

  // ---- stage p1: response buffer ----
  assign pop_p1 = resp_ready && !empty_p1;

  inst_resp_fifo #(
    .W ($bits(resp_p_t))
  ) u_resp_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_p0),
    .pop    (pop_p1),
    .flush  (flush),
    .din    (push_data_p0),
    .dout   (head_p1),
    .empty  (empty_p1),
    .full   (full_p1)
  );

  // Outputs are forced to zero while empty so reset/flush clear them
  // without resetting the buffer storage itself.
  assign resp_valid = !empty_p1;
  assign resp_rdata = empty_p1 ? '0   : head_p1.rdata;
  assign resp_err   = empty_p1 ? 1'b0 : head_p1.err;

endmodule

// File: doc/inst_sram_pipe.md
# inst_sram_pipe

Parametrised instruction memory with a request/response handshake, replacing the flat combinational-read instruction SRAM in the fetch path. Fetch requests are accepted on a valid/ready handshake, read synchronously and queued in a 2-entry response buffer, so the IF stage can stall without losing data. The block also provides a byte-strobed loader write port, alignment and range checking, and a flush for redirects.

## Interface
- DATA_W, 32, instruction word width; multiple of 8.
- ADDR_W, 64, byte-address width (nextpc width).
- DEPTH, 128, words; power of 2.
- BASE_ADDR, 0, byte address of word 0; DATA_W/8-aligned.

- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_addr  in  ADDR_W  fetch byte address.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  DATA_W  instruction word.
- resp_err  out  1  misaligned or out-of-range request.
- flush  in  1  discard all buffered responses; block new requests this cycle.
- wr_en  in  DATA_W/8  per-byte write strobes.
- wr_addr  in  ADDR_W  write byte address.
- wr_data  in  DATA_W  write data.

## Operation
- Index is (addr − BASE_ADDR) >> log2(DATA_W/8).
- Misaligned: addr low log2(DATA_W/8) bits ≠ 0.
- Out-of-range: addr < BASE_ADDR or index ≥ DEPTH.
- On an accepted request, the word at index is captured into the response buffer tail.
  - Misaligned or out-of-range requests store rdata=0 with err=1.
  - Otherwise err=0.
- Response buffer: 2-entry FIFO. resp_valid = !empty. Head drives resp_rdata and resp_err.
- req_ready = !full & !flush. There is no combinational path from resp_ready to req_ready.
- Pop happens on resp_valid & resp_ready.
- Push and pop in the same cycle on a non-full buffer: count is unchanged.
- A full buffer with a pop in that cycle still deasserts req_ready (registered decision).
- flush: next cycle the buffer is empty and resp_valid=0.
  - Any pop that cycle is irrelevant.
  - No push occurs, because req_ready is forced low.
- Write port: bytes with wr_en[i]=1 are written at the rising edge.
  - Misaligned or out-of-range writes are dropped silently.
  - Writes are independent of the read handshake.
- Same-cycle write and read to the same index: the read is write-first. The captured word reflects the strobed new bytes merged with the old bytes.
- Memory contents are not reset. The simulation initial value is undefined.

## Timing
- Reset (asynchronous assert, synchronous deassert by the environment):
  - buffer empty.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - req_ready=1 on the first cycle after deassert.
- Latency: request accepted at edge N → resp_valid=1 after edge N (cycle N+1), data stable until popped.
- Full throughput: 1 request/cycle sustained while resp_ready=1.
- resp_ready low for 2 cycles with requests pending → buffer fills, and req_ready falls in the cycle after the second accept.
- resp_rdata and resp_err hold while resp_valid & !resp_ready.
- resetn asserted mid-stream: buffer cleared immediately and outputs go to reset values. Memory contents are retained.

## Structure
- Package inst_mem_pkg holds:
  - defaults for DATA_W, ADDR_W, DEPTH, BASE_ADDR;
  - a response struct type {err, rdata};
  - a helper function computing index, misaligned and out-of-range flags.
- Sub-module inst_resp_fifo is a 2-entry synchronous FIFO.
  - Ports: clk, resetn, push, pop, flush, din, dout, empty, full.
  - It is instantiated once.
- Top level contains the memory array, write-merge logic, address checks and handshake glue.

## Test plan
- Reset, then load via the write port: wr_en=4'hF, addr 0x0/0x4/0x8 with 0x11111111/0x22222222/0x33333333. Then read 0x0, 0x4, 0x8 back-to-back with resp_ready=1 → one response per cycle from cycle N+1, values in order, err=0.
- Backpressure: resp_ready=0 with 3 requests offered → two accepted, req_ready=0 afterwards. Then resp_ready=1 → 0x11111111, 0x22222222 drain in order and the third request is accepted.
- Errors: requests at addr 0x2 and at BASE_ADDR + 4·DEPTH → resp_rdata=0, resp_err=1, and the next valid read returns correct data.
- Byte strobe with same-cycle read: word 0x4 = 0x22222222, write wr_en=4'b0101, wr_data=0xAABBCCDD while reading 0x4 → response 0x22BB22DD, and a later read gives the same value.
- Flush: 2 responses buffered, flush=1 with req_valid=1 → req_ready=0 that cycle, resp_valid=0 next cycle, and a subsequent request returns fresh data at latency 1.
- Async reset mid-stream: resetn low with a full buffer → resp_valid drops immediately. After release, req_ready=1 and the earlier written data still reads back.
